instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart to the opcode decoder in the single-cycle RV32I core.
- Accepts instruction descriptions (class plus fields) over a valid/ready handshake and assembles RV32I 32-bit words for the four classes the control unit decodes: R-type, LOAD, STORE and BRANCH.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory.
- Used to load programs and self-test sequences before the core runs.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- DEPTH, 4, FIFO depth in words (power of two, ≥2).
- BASE_ADDR, 0, first write address (word aligned).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear; same effect as reset.
- req_valid  in  1  request valid.
- req_ready  out  1  encoder can accept a request.
- req_type  in  2  0=R, 1=LOAD, 2=STORE, 3=BRANCH.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R-type only).
- imm  in  12  I/S immediate; for BRANCH, byte offset bits [12:1].
- imem_we  out  1  memory write strobe.
- imem_addr  out  ADDR_W  byte write address.
- imem_wdata  out  32  encoded word.
- imem_ready  in  1  memory accepts the write this cycle.
- wr_count  out  ADDR_W  number of words written since reset/clear.
- enc_err  out  1  sticky field error (optional feature only).

Behaviour:
- Reset/clear values: FIFO empty, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, wr_count=0, enc_err=0, req_ready=1 on the next cycle.
- Accept occurs when req_valid && req_ready; the encoded word is pushed on that clk edge.
- req_ready = !full; it does not depend on pop in the same cycle (no pass-through when full).
- Encodings, opcode in [6:0]:
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - LOAD: imm[11:0]|rs1|funct3|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - BRANCH: inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0], rs2, rs1, funct3, opcode 1100011; rd is ignored.
- Output side: imem_we = FIFO not empty; imem_wdata = FIFO head (registered FIFO storage).
- Pop on imem_we && imem_ready. The same edge adds 4 to imem_addr (mod 2^ADDR_W, wraps silently) and adds 1 to wr_count (wraps).
- Latency: request accepted at edge N appears on imem_wdata/imem_we after edge N; it is written at the first edge where imem_ready=1.
- While imem_ready=0: imem_we, imem_addr and imem_wdata hold stable.
- Simultaneous push and pop when not full: occupancy unchanged, order preserved.
- Push when empty: word visible next cycle.
- Reset or clear mid-operation: all buffered words are discarded and the address returns to BASE_ADDR; a request presented in the same cycle is not accepted.
- FIFO pointers are log2(DEPTH) bits plus one wrap bit for full/empty.

Optional Feature:
- Macro: INSTR_ENCODER_CHECK_EN.
- Defined:
  - Illegal requests are not pushed. Illegal means: R-type with funct7 ∉ {0x00,0x20}, or (funct7=0x20 and funct3 ∉ {000,101}); BRANCH with funct3 ∈ {010,011}; LOAD with funct3 ∈ {011,110,111}; STORE with funct3 > 010.
  - The request is still consumed (handshake completes) and enc_err is set until reset/clear.
- Undefined: every request is encoded as given and enc_err is tied to 0.

Decomposition:
- Shared package (core_pkg):
  - Opcode constants OP_R=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011.
  - Request-class encoding (2-bit).
  - Instruction-field bit positions.
- Sub-module: sync_fifo (WIDTH=32, DEPTH), which owns the pointers, full/empty and storage.
- Encode mux and the address/count logic stay in the top module.

Test Plan:
- R add x3,x1,x2 (funct7=0, funct3=0), imem_ready=1 → one write: addr 0x000, data 0x002081B3, wr_count=1.
- LOAD lw x5,8(x2) then STORE sw x5,12(x2) back-to-back → data 0x00812283 at addr 0x000, 0x00512623 at 0x004.
- BRANCH beq x1,x2,+16 (imm=12'h008) → 0x00208863; beq x0,x0,-4 (imm=12'hFFE) → 0xFE000EE3.
- imem_ready=0 while issuing 5 requests → exactly 4 accepted, req_ready=0 on the 5th, outputs stable. Then raise imem_ready → 4 writes in order, then the 5th is accepted.
- ADDR_W=4, 5 writes → addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap). Assert clear with 2 words buffered → FIFO empty and addr=BASE_ADDR next cycle, no further writes.
- With INSTR_ENCODER_CHECK_EN: R-type with funct7=0x01 → handshake completes, no write, enc_err=1 and it stays set until reset.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I encoding definitions: major opcodes, request classes and
// instruction-field bit positions, plus the request legality rule used when
// INSTR_ENCODER_CHECK_EN is defined.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    REQ_R      = 2'd0,
    REQ_LOAD   = 2'd1,
    REQ_STORE  = 2'd2,
    REQ_BRANCH = 2'd3
  } req_type_e;

  // Field LSB positions inside the 32-bit instruction word.
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  // True when the field combination is not a real RV32I instruction of that class.
  function automatic logic is_illegal(input logic [1:0] t,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
    logic bad;
    bad = 1'b0;
    case (t)
      REQ_R: begin
        if (f7 == 7'h20) begin
          bad = (f3 != 3'b000) && (f3 != 3'b101);
        end else begin
          bad = (f7 != 7'h00);
        end
      end
      REQ_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      REQ_STORE:  bad = (f3 > 3'b010);
      REQ_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage. Pointers carry one extra wrap
// bit so full and empty are distinguished without a counter. The head word
// is read combinationally from the registered array.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                 (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rdata     = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Pointer and storage update; reset/clear discard everything and zero the head.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= wdata;
        r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles R/LOAD/STORE/BRANCH words from field
// requests, buffers them in a FIFO and streams them into instruction memory
// at consecutive word addresses starting from BASE_ADDR.
// Optional build macro INSTR_ENCODER_CHECK_EN: drops illegal requests and
// raises a sticky enc_err; without it every request is encoded as given.
module instr_encoder
  import core_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] wr_count,
  output logic              enc_err
);

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;
  logic [31:0] w_head;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;

  assign req_ready = !w_full;
  assign w_accept  = req_valid && !w_full && !reset && !clear;
  assign w_pop     = !w_empty && imem_ready;

  // Encode mux: place request fields at their RV32I positions per class.
  always_comb begin
    w_word = 32'h0000_0000;
    w_word[F3_LSB  +: 3] = funct3;
    w_word[RS1_LSB +: 5] = rs1;
    case (req_type)
      REQ_R: begin
        w_word[6:0]          = OP_R;
        w_word[RD_LSB  +: 5] = rd;
        w_word[RS2_LSB +: 5] = rs2;
        w_word[F7_LSB  +: 7] = funct7;
      end
      REQ_LOAD: begin
        w_word[6:0]          = OP_LOAD;
        w_word[RD_LSB  +: 5] = rd;
        w_word[31:20]        = imm;
      end
      REQ_STORE: begin
        w_word[6:0]          = OP_STORE;
        w_word[11:7]         = imm[4:0];
        w_word[RS2_LSB +: 5] = rs2;
        w_word[31:25]        = imm[11:5];
      end
      REQ_BRANCH: begin
        // imm holds byte-offset bits [12:1], so imm[k] is offset bit k+1.
        w_word[6:0]          = OP_BRANCH;
        w_word[7]            = imm[10];
        w_word[11:8]         = imm[3:0];
        w_word[RS2_LSB +: 5] = rs2;
        w_word[30:25]        = imm[9:4];
        w_word[31]           = imm[11];
      end
      default: begin
        w_word = 32'h0000_0000;
      end
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic r_err;
  logic w_illegal;

  assign w_illegal = is_illegal(req_type, funct3, funct7);
  assign w_push    = w_accept && !w_illegal;
  assign enc_err   = r_err;

  // Sticky error flag: set on any consumed illegal request, cleared only by reset/clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end
`else
  assign w_push  = w_accept;
  assign enc_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign imem_we    = !w_empty;
  assign imem_wdata = w_head;
  assign imem_addr  = r_addr;
  assign wr_count   = r_count;

  // Write address and written-word counter advance together on each completed write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (w_pop) begin
      r_addr  <= r_addr + ADDR_W'(3'd4);
      r_count <= r_count + ADDR_W'(1'b1);
    end else begin
      r_addr  <= r_addr;
      r_count <= r_count;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected words when a
// request is accepted, a negedge monitor compares every memory write,
// address, count, ready and error flag against a reference model.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_type = 2'd0;
  logic [4:0]        rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]        funct3 = 3'd0;
  logic [6:0]        funct7 = 7'd0;
  logic [11:0]       imm = 12'd0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b0;
  logic [ADDR_W-1:0] wr_count;
  logic              enc_err;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR('0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .wr_count(wr_count), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          model_addr = 0;
  int          model_cnt  = 0;
  bit          model_err  = 1'b0;
  bit          mon_en     = 1'b0;
  bit          rand_on    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: standard RV32I layouts; branch built from the 13-bit byte offset.
  function automatic logic [31:0] ref_encode(input logic [1:0] t, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [11:0] im);
    logic [12:0] off;
    off = {im, 1'b0};
    case (t)
      2'd0:    return {f7, s2, s1, f3, d, 7'h33};
      2'd1:    return {im, s1, f3, d, 7'h03};
      2'd2:    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
      default: return {off[12], off[10:5], s2, s1, f3, off[4:1], off[11], 7'h63};
    endcase
  endfunction

  function automatic bit ref_legal(input logic [1:0] t, input logic [2:0] f3, input logic [6:0] f7);
`ifdef INSTR_ENCODER_CHECK_EN
    case (t)
      2'd0:    return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      2'd1:    return !(f3 inside {3'd3, 3'd6, 3'd7});
      2'd2:    return f3 <= 3'd2;
      default: return !(f3 inside {3'd2, 3'd3});
    endcase
`else
    return 1'b1;
`endif
  endfunction

  // Present one request and hold it until accepted (bounded wait).
  task automatic issue(input logic [1:0] t, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [11:0] im, input logic [31:0] exp_word);
    int waited;
    bit done;
    req_type = t; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    req_valid = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      if (req_ready) begin
        if (ref_legal(t, f3, f7)) exp_q.push_back(exp_word);
        else model_err = 1'b1;
        done = 1'b1;
      end else if (waited > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      waited++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Monitor: compare DUT outputs with the scoreboard between clock edges.
  always @(negedge clk) begin
    if (mon_en) begin
      if (clear) begin
        exp_q.delete();
        model_addr = 0;
        model_cnt  = 0;
        model_err  = 1'b0;
      end else begin
        chk("wr_count", 32'(wr_count), 32'(model_cnt));
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
        chk("enc_err", 32'(enc_err), 32'(model_err));
        chk("imem_we", 32'(imem_we), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("imem_wdata", imem_wdata, exp_q[0]);
          chk("imem_addr", 32'(imem_addr), 32'(model_addr));
          if (imem_ready && imem_we) begin
            void'(exp_q.pop_front());
            model_addr = (model_addr + 4) % (1 << ADDR_W);
            model_cnt  = (model_cnt + 1) % (1 << ADDR_W);
          end
        end
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_err", 32'(enc_err), 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    imem_ready = 1'b1;

    // add x3,x1,x2 ; lw x5,8(x2) ; sw x5,12(x2) ; beq +16 ; beq x0,x0,-4
    issue(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'h002081B3);
    drain();
    issue(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 12'd8, 32'h00812283);
    issue(2'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 12'd12, 32'h00512623);
    issue(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 12'h008, 32'h00208863);
    issue(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'hFFE, 32'hFE000EE3);
    drain();

    // Stall: four fill the FIFO, fifth waits until memory drains.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(2'd0, 5'(i + 1), 5'd7, 5'd9, 3'd0, 7'h00, 12'h000,
            ref_encode(2'd0, 5'(i + 1), 5'd7, 5'd9, 3'd0, 7'h00, 12'h000));
    fork
      issue(2'd1, 5'd10, 5'd11, 5'd0, 3'd0, 7'h00, 12'h123,
            ref_encode(2'd1, 5'd10, 5'd11, 5'd0, 3'd0, 7'h00, 12'h123));
      begin repeat (6) @(posedge clk); #1 imem_ready = 1'b1; end
    join
    drain();

    // Clear with two words buffered and a request presented in the same cycle.
    imem_ready = 1'b0;
    issue(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 12'h000, ref_encode(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 12'h000));
    issue(2'd2, 5'd0, 5'd2, 5'd3, 3'd1, 7'h00, 12'h7FF, ref_encode(2'd2, 5'd0, 5'd2, 5'd3, 3'd1, 7'h00, 12'h7FF));
    clear = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    req_valid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("clr_addr", 32'(imem_addr), 32'd0);
    chk("clr_we", 32'(imem_we), 32'd0);
    repeat (3) @(posedge clk);
    #1;

`ifdef INSTR_ENCODER_CHECK_EN
    issue(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h01, 12'h000, 32'd0);
    drain();
    chk("err_sticky", 32'(enc_err), 32'd1);
`endif

    // Random traffic with random memory back-pressure; wraps the address space.
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [1:0] t; logic [4:0] d, a, b; logic [2:0] f3; logic [6:0] f7; logic [11:0] im;
          t = 2'($urandom); d = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
          f3 = 3'($urandom); im = 12'($urandom);
          f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
          issue(t, d, a, b, f3, f7, im, ref_encode(t, d, a, b, f3, f7, im));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          imem_ready = ($urandom_range(0, 3) != 0);
        end
        imem_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
